mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/rv32i_types.sv | 14 +
 rtl/wait_timer.sv | 31 +++
 rtl/mem_bridge.sv | 143 ++++++++++++++
 tb/tb_mem_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Types shared by the memory bridge and its wait timer.
package rv32i_types;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP,
      S_ERR
   } bridge_state_t;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wait_timer.sv
// Counts cycles spent waiting for a downstream response.
// It flags expiry once TIMEOUT-1 cycles have been counted.
module wait_timer
   import rv32i_types::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // One spare count keeps the counter from wrapping on its final increment.
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_count;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Single-outstanding bridge from a level-held CPU memory request to a
// ready/valid downstream port. It has a wait timeout and a sticky error.
module mem_bridge
   import rv32i_types::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic [31:0] dmem_addr,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_bvalid,
   output logic        busy,
   output logic        err
);

   bridge_state_t r_state;
   logic          r_op_write;
   logic          r_mem_resp;
   logic          r_dmem_read;
   logic          r_dmem_write;
   logic          r_busy;
   logic          r_err;
   logic [31:0]   r_mem_rdata;
   logic [31:0]   r_dmem_addr;
   logic [3:0]    r_dmem_wmask;
   logic [31:0]   r_dmem_wdata;

   logic          w_timer_clr;
   logic          w_timer_en;
   logic          w_expired;
   logic          w_unused_addr_lsb;

   assign w_timer_clr       = (r_state == S_REQ) && dmem_ready;
   assign w_timer_en        = (r_state == S_WAIT);
   // Downstream addresses are word aligned, so the byte offset is dropped.
   assign w_unused_addr_lsb = ^mem_addr[1:0];

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_timer_clr),
      .en      (w_timer_en),
      .expired (w_expired)
   );

   // NOTE: reset is synchronous, so it is sampled inside the clocked block like any other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_op_write   <= 1'b0;
         r_mem_resp   <= 1'b0;
         r_dmem_read  <= 1'b0;
         r_dmem_write <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_mem_rdata  <= '0;
         r_dmem_addr  <= '0;
         r_dmem_wmask <= '0;
         r_dmem_wdata <= '0;
      end else begin
         r_mem_resp <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_read && mem_write) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_ERR;
               end else if (mem_read || mem_write) begin
                  r_op_write   <= mem_write;
                  r_dmem_addr  <= {mem_addr[31:2], 2'b00};
                  r_dmem_wmask <= mem_wmask;
                  r_dmem_wdata <= mem_wdata;
                  r_dmem_read  <= mem_read;
                  r_dmem_write <= mem_write;
                  r_busy       <= 1'b1;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_ready) begin
                  r_dmem_read  <= 1'b0;
                  r_dmem_write <= 1'b0;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A matching response on the final count still completes normally.
               if (!r_op_write && dmem_rvalid) begin
                  r_mem_rdata <= dmem_rdata;
                  r_mem_resp  <= 1'b1;
                  r_state     <= S_RESP;
               end else if (r_op_write && dmem_bvalid) begin
                  r_mem_rdata <= '0;
                  r_mem_resp  <= 1'b1;
                  r_state     <= S_RESP;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end
            end
            S_RESP: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_err   <= 1'b1;
               r_busy  <= 1'b1;
               r_state <= S_ERR;
            end
         endcase
      end
   end

   assign mem_rdata  = r_mem_rdata;
   assign mem_resp   = r_mem_resp;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_read  = r_dmem_read;
   assign dmem_write = r_dmem_write;
   assign dmem_wmask = r_dmem_wmask;
   assign dmem_wdata = r_dmem_wdata;
   assign busy       = r_busy;
   assign err        = r_err;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: a transaction-level model (expected
// request and response queues) plus directed and randomized traffic.
module tb_mem_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic [31:0] dmem_addr;
   logic        dmem_read;
   logic        dmem_write;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        dmem_bvalid;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   mem_bridge #(
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wmask   (mem_wmask),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .dmem_addr   (dmem_addr),
      .dmem_read   (dmem_read),
      .dmem_write  (dmem_write),
      .dmem_wmask  (dmem_wmask),
      .dmem_wdata  (dmem_wdata),
      .dmem_ready  (dmem_ready),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .dmem_bvalid (dmem_bvalid),
      .busy        (busy),
      .err         (err)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } req_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_issued = 0;
   int          n_seen   = 0;
   bit          err_expected = 1'b0;
   req_t        exp_req[$];
   logic [31:0] exp_resp[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks every cycle against the transaction model
   bit          active     = 1'b0;
   bit          prev_resp  = 1'b0;
   req_t        cur;
   logic [31:0] last_rdata = '0;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         active     = 1'b0;
         prev_resp  = 1'b0;
         last_rdata = '0;
      end else if (rst === 1'b0) begin
         if (dmem_read || dmem_write) begin
            if (!active) begin
               n_seen++;
               if (exp_req.size() == 0) begin
                  check("unexpected_dmem_req", 32'd1, 32'd0);
                  cur = '{wr: dmem_write, addr: dmem_addr, wmask: dmem_wmask, wdata: dmem_wdata};
               end else begin
                  cur = exp_req.pop_front();
               end
               active = 1'b1;
            end
            check("dmem_read",  dmem_read,  !cur.wr);
            check("dmem_write", dmem_write, cur.wr);
            check("dmem_addr",  dmem_addr,  cur.addr);
            check("dmem_wmask", dmem_wmask, cur.wmask);
            check("dmem_wdata", dmem_wdata, cur.wdata);
            if (dmem_ready) active = 1'b0;
         end else if (active) begin
            check("dmem_req_held", 32'd0, 32'd1);
            active = 1'b0;
         end
         if (mem_resp) begin
            check("resp_single", prev_resp, 1'b0);
            if (exp_resp.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else last_rdata = exp_resp.pop_front();
         end
         check("mem_rdata", mem_rdata, last_rdata);
         if (active || mem_resp) check("busy_active", busy, 1'b1);
         if (!err_expected) check("err_clear", err, 1'b0);
         prev_resp = mem_resp;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_bvalid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      idle_inputs();
      repeat (cycles) tick();
      exp_req.delete();
      exp_resp.delete();
      rst = 1'b0;
      err_expected = 1'b0;
   endtask

   task automatic wait_dmem_req(output int waited);
      bit seen = 1'b0;
      waited = 0;
      for (int i = 0; i < 4 && !seen; i++) begin
         tick();
         waited++;
         seen = dmem_read || dmem_write;
      end
      if (!seen) check("dmem_req_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_req(input bit wr, input logic [31:0] addr, input logic [3:0] wm,
                             input logic [31:0] wd);
      req_t r;
      r.wr    = wr;
      r.addr  = addr & 32'hFFFF_FFFC;
      r.wmask = wm;
      r.wdata = wd;
      exp_req.push_back(r);
      n_issued++;
   endtask

   // Full transaction; returns in the completion cycle with the request dropped
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] wm,
                          input logic [31:0] wd, input logic [31:0] rd, input int rdy_dly,
                          input int rsp_dly, input bit noise, output int waited);
      expect_req(wr, addr, wm, wd);
      exp_resp.push_back(wr ? 32'h0 : rd);
      mem_read  = !wr;
      mem_write = wr;
      mem_addr  = addr;
      mem_wmask = wm;
      mem_wdata = wd;
      wait_dmem_req(waited);
      for (int i = 0; i < rdy_dly; i++) begin
         dmem_rvalid = noise && ($urandom_range(0, 1) == 1);
         dmem_bvalid = noise && ($urandom_range(0, 1) == 1);
         dmem_rdata  = $urandom;
         tick();
      end
      dmem_ready  = 1'b1;
      dmem_rvalid = noise && ($urandom_range(0, 1) == 1);
      dmem_bvalid = noise && ($urandom_range(0, 1) == 1);
      tick();
      dmem_ready = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
         dmem_rvalid = noise && wr && ($urandom_range(0, 1) == 1);
         dmem_bvalid = noise && !wr && ($urandom_range(0, 1) == 1);
         dmem_rdata  = $urandom;
         if (noise) begin
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wmask = 4'($urandom_range(0, 15));
            mem_read  = ($urandom_range(0, 1) == 1);
            mem_write = ($urandom_range(0, 1) == 1);
         end
         tick();
      end
      dmem_rvalid = !wr;
      dmem_bvalid = wr;
      dmem_rdata  = wr ? $urandom : rd;
      tick();
      dmem_rvalid = 1'b0;
      dmem_bvalid = 1'b0;
      check("resp_latency", mem_resp, 1'b1);
      check("resp_rdata", mem_rdata, wr ? 32'h0 : rd);
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          waited;
      logic [31:0] val;

      mem_addr   = '0;
      mem_wmask  = '0;
      mem_wdata  = '0;
      dmem_rdata = '0;
      do_reset(3);

      // Reset values (rst released just now, outputs reflect reset)
      check("rst_mem_resp",   mem_resp,   1'b0);
      check("rst_dmem_read",  dmem_read,  1'b0);
      check("rst_dmem_write", dmem_write, 1'b0);
      check("rst_busy",       busy,       1'b0);
      check("rst_err",        err,        1'b0);
      check("rst_mem_rdata",  mem_rdata,  32'h0);
      check("rst_dmem_addr",  dmem_addr,  32'h0);
      check("rst_dmem_wmask", dmem_wmask, 4'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);

      // Directed read with exact cycle timing
      expect_req(1'b0, 32'h4000_0006, 4'h0, 32'h0);
      exp_resp.push_back(32'hDEAD_BEEF);
      mem_read  = 1'b1;
      mem_addr  = 32'h4000_0006;
      mem_wmask = 4'h0;
      mem_wdata = 32'h0;
      tick();
      check("r37_dmem_read", dmem_read, 1'b1);
      check("r37_dmem_addr", dmem_addr, 32'h4000_0004);
      check("r37_busy",      busy,      1'b1);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      check("r37_req_dropped", dmem_read, 1'b0);
      tick();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD_BEEF;
      tick();
      dmem_rvalid = 1'b0;
      check("r37_resp",  mem_resp,  1'b1);
      check("r37_rdata", mem_rdata, 32'hDEAD_BEEF);
      mem_read = 1'b0;
      tick();
      check("r37_resp_once", mem_resp,  1'b0);
      check("r37_idle_busy", busy,      1'b0);
      check("r37_rdata_hold", mem_rdata, 32'hDEAD_BEEF);

      // Write with a stalled ready and delayed acknowledge
      run_txn(1'b1, 32'h4000_0010, 4'b1100, 32'hABCD_0000, 32'h0, 5, 2, 1'b0, waited);
      check("r38_rdata_zero", mem_rdata, 32'h0);

      // Back-to-back read presented right after completion
      run_txn(1'b0, 32'h1234_5679, 4'hF, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0, waited);
      check("r39_capture_latency", waited, 32'd2);
      check("r39_rdata", mem_rdata, 32'h5555_AAAA);

      // Response arriving on the final permitted wait cycle
      run_txn(1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'hC0FF_EE00, 1, TO - 1, 1'b0, waited);

      // Randomized traffic with stray responses and CPU input noise
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         val = $urandom;
         run_txn(($urandom_range(0, 1) == 1), $urandom, 4'($urandom_range(0, 15)), $urandom,
                 val, $urandom_range(0, 4), $urandom_range(0, TO - 2), 1'b1, waited);
      end
      tick();
      check("dmem_req_count", n_seen, n_issued);
      check("resp_queue_empty", exp_resp.size(), 32'd0);

      // Reset in the middle of a wait, followed by a late response
      expect_req(1'b0, 32'h2000_0008, 4'h3, 32'h1111_2222);
      mem_read  = 1'b1;
      mem_addr  = 32'h2000_0008;
      mem_wmask = 4'h3;
      mem_wdata = 32'h1111_2222;
      wait_dmem_req(waited);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      tick();
      rst      = 1'b1;
      mem_read = 1'b0;
      tick();
      rst         = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      check("r42_busy",       busy,       1'b0);
      check("r42_dmem_addr",  dmem_addr,  32'h0);
      check("r42_dmem_wmask", dmem_wmask, 4'h0);
      tick();
      dmem_rvalid = 1'b0;
      check("r42_no_resp",    mem_resp,   1'b0);
      check("r42_err",        err,        1'b0);
      check("r42_rdata",      mem_rdata,  32'h0);
      check("r42_dmem_read",  dmem_read,  1'b0);

      // Read and write requested together
      err_expected = 1'b1;
      mem_read  = 1'b1;
      mem_write = 1'b1;
      tick();
      check("r41_err",  err,  1'b1);
      check("r41_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r41_no_dmem", {dmem_read, dmem_write}, 2'b00);
         check("r41_no_resp", mem_resp, 1'b0);
      end
      do_reset(2);

      // Timeout: read accepted, never answered
      err_expected = 1'b1;
      expect_req(1'b0, 32'h3000_0000, 4'h0, 32'h0);
      mem_read  = 1'b1;
      mem_addr  = 32'h3000_0000;
      mem_wmask = 4'h0;
      mem_wdata = 32'h0;
      wait_dmem_req(waited);
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      for (int i = 1; i < TO; i++) begin
         tick();
         check("r40_err_early", err, 1'b0);
      end
      tick();
      check("r40_err",     err,      1'b1);
      check("r40_busy",    busy,     1'b1);
      check("r40_no_resp", mem_resp, 1'b0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hBAD0_BAD0;
      tick();
      dmem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r40_terminal_resp", mem_resp, 1'b0);
         check("r40_terminal_busy", busy, 1'b1);
         check("r40_terminal_dmem", {dmem_read, dmem_write}, 2'b00);
      end
      do_reset(2);
      check("final_err_cleared", err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
